// File: rtl/match_controller.sv
// match_controller: round/score sequencer for the two-tank game.
// Steps a match FSM (title -> play -> hit freeze -> round over -> match over) once per
// frame_tick, detects bullet-on-tank hits with one frame of latency, keeps saturating
// scores and issues a one-Clk round_reset pulse that re-spawns tanks and clears the map.
//
// Ports:
//   Clk, Reset             clock, synchronous active-high reset
//   frame_tick             one-Clk pulse per game frame
//   keycode[7:0]           current USB keycode (0 = none)
//   tank{1,2}{x,y}[9:0]    tank centres, pixels
//   bul{1,2}{x,y}[9:0]     bullet centres, pixels
//   bul{1,2}_active        bullet in flight
//   score1/score2[3:0]     player scores for the HEX digits
//   state[2:0]             encoded FSM state (debug/LEDs)
//   game_active            high only in PLAY
//   freeze                 high in FREEZE and ROUND_OVER
//   round_reset            one-Clk respawn/clear pulse
//   winner[1:0]            00 none, 01 P1, 10 P2, 11 draw round
module match_controller #(
  parameter int unsigned HIT_RADIUS    = 12,
  parameter int unsigned FREEZE_FRAMES = 90,
  parameter int unsigned WIN_SCORE     = 5,
  parameter logic [7:0]  START_KEY     = 8'h2C
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic [7:0] keycode,
  input  logic [9:0] tank1x,
  input  logic [9:0] tank1y,
  input  logic [9:0] tank2x,
  input  logic [9:0] tank2y,
  input  logic [9:0] bul1x,
  input  logic [9:0] bul1y,
  input  logic [9:0] bul2x,
  input  logic [9:0] bul2y,
  input  logic       bul1_active,
  input  logic       bul2_active,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic [2:0] state,
  output logic       game_active,
  output logic       freeze,
  output logic       round_reset,
  output logic [1:0] winner
);

  localparam int unsigned CntW = $clog2(FREEZE_FRAMES + 1);

  typedef enum logic [2:0] {
    StTitle     = 3'd0,
    StPlay      = 3'd1,
    StFreeze    = 3'd2,
    StRoundOver = 3'd3,
    StMatchOver = 3'd4
  } state_e;

  // Held as plain bits so illegal codes 5..7 are representable and recoverable.
  logic [2:0]      state_q, state_d;
  logic [3:0]      score1_q, score1_d, score2_q, score2_d;
  logic [1:0]      winner_q, winner_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            armed_q, armed_d;
  logic            hit1_q, hit1_d, hit2_q, hit2_d;
  logic            round_reset_q, round_reset_d;
  logic            rst_pending_q;
  logic            rr_req;

  // 11-bit signed difference then magnitude: no wraparound at screen edges.
  function automatic logic near(input logic [9:0] a, input logic [9:0] b);
    logic signed [10:0] d;
    logic [10:0]        m;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    m = d[10] ? $unsigned(-d) : $unsigned(d);
    return m < 11'(HIT_RADIUS);
  endfunction

  always_comb begin
    state_d  = state_q;
    score1_d = score1_q;
    score2_d = score2_q;
    winner_d = winner_q;
    cnt_d    = cnt_q;
    armed_d  = armed_q;
    hit1_d   = hit1_q;
    hit2_d   = hit2_q;
    rr_req   = 1'b0;

    if (frame_tick) begin
      // Registered compare, consumed on the following frame_tick.
      hit1_d = (state_q == StPlay) && bul1_active && near(bul1x, tank2x) && near(bul1y, tank2y);
      hit2_d = (state_q == StPlay) && bul2_active && near(bul2x, tank1x) && near(bul2y, tank1y);
    end

    case (state_q)
      StTitle: begin
        if (frame_tick && keycode == START_KEY) begin
          score1_d = '0;
          score2_d = '0;
          winner_d = 2'b00;
          rr_req   = 1'b1;
          state_d  = StPlay;
        end
      end
      StPlay: begin
        if (frame_tick && (hit1_q || hit2_q)) begin
          cnt_d   = '0;
          state_d = StFreeze;
          if (hit1_q && hit2_q) begin
            winner_d = 2'b11;
          end else if (hit1_q) begin
            winner_d = 2'b01;
            score1_d = (score1_q == 4'd15) ? 4'd15 : score1_q + 4'd1;
          end else begin
            winner_d = 2'b10;
            score2_d = (score2_q == 4'd15) ? 4'd15 : score2_q + 4'd1;
          end
        end
      end
      StFreeze: begin
        if (frame_tick) begin
          if (cnt_q == CntW'(FREEZE_FRAMES - 1)) begin
            state_d = StRoundOver;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StRoundOver: begin
        if (frame_tick) begin
          if (score1_q >= 4'(WIN_SCORE) || score2_q >= 4'(WIN_SCORE)) begin
            armed_d = 1'b0;
            state_d = StMatchOver;
          end else begin
            rr_req   = 1'b1;
            winner_d = 2'b00;
            state_d  = StPlay;
          end
        end
      end
      StMatchOver: begin
        // A held start key must be released once before it can restart the game.
        if (frame_tick) begin
          if (!armed_q) begin
            if (keycode == 8'h00) armed_d = 1'b1;
          end else if (keycode == START_KEY) begin
            state_d = StTitle;
          end
        end
      end
      default: state_d = StTitle;
    endcase

    // Post-reset pulse and FSM requests merge; the pulse never repeats on back-to-back Clks.
    round_reset_d = (rst_pending_q | rr_req) & ~round_reset_q;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q       <= StTitle;
      score1_q      <= '0;
      score2_q      <= '0;
      winner_q      <= 2'b00;
      cnt_q         <= '0;
      armed_q       <= 1'b0;
      hit1_q        <= 1'b0;
      hit2_q        <= 1'b0;
      round_reset_q <= 1'b0;
      rst_pending_q <= 1'b1;
    end else begin
      state_q       <= state_d;
      score1_q      <= score1_d;
      score2_q      <= score2_d;
      winner_q      <= winner_d;
      cnt_q         <= cnt_d;
      armed_q       <= armed_d;
      hit1_q        <= hit1_d;
      hit2_q        <= hit2_d;
      round_reset_q <= round_reset_d;
      rst_pending_q <= 1'b0;
    end
  end

  assign score1      = score1_q;
  assign score2      = score2_q;
  assign state       = state_q;
  assign winner      = winner_q;
  assign round_reset = round_reset_q;
  assign game_active = (state_q == StPlay);
  assign freeze      = (state_q == StFreeze) || (state_q == StRoundOver);

endmodule

// File: tb/tb_match_controller.sv
// Self-checking bench for match_controller: directed scenarios plus randomized play
// checked against a rule-level reference model of the match.
module tb_match_controller;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic [7:0] keycode = 8'h00;
  logic [9:0] tank1x = 10'd300, tank1y = 10'd300, tank2x = 10'd600, tank2y = 10'd200;
  logic [9:0] bul1x = 10'd0, bul1y = 10'd0, bul2x = 10'd0, bul2y = 10'd0;
  logic       bul1_active = 1'b0, bul2_active = 1'b0;
  logic [3:0] score1, score2;
  logic [2:0] state;
  logic       game_active, freeze, round_reset;
  logic [1:0] winner;

  int checks = 0;
  int errors = 0;

  // Reference model: match state kept as plain integers
  int m_state, m_s1, m_s2, m_win, m_left, m_armed, m_h1, m_h2, m_rr;
  logic rr_seen, rr_after;

  match_controller dut (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .keycode(keycode),
    .tank1x(tank1x), .tank1y(tank1y), .tank2x(tank2x), .tank2y(tank2y),
    .bul1x(bul1x), .bul1y(bul1y), .bul2x(bul2x), .bul2y(bul2y),
    .bul1_active(bul1_active), .bul2_active(bul2_active),
    .score1(score1), .score2(score2), .state(state), .game_active(game_active),
    .freeze(freeze), .round_reset(round_reset), .winner(winner)
  );

  always #5 Clk = ~Clk;

  function automatic int m_near(input int a, input int b);
    int d;
    d = a - b;
    if (d < 0) d = -d;
    return (d < 12) ? 1 : 0;
  endfunction

  function automatic logic [9:0] clip(input int v);
    if (v < 0) return 10'd0;
    if (v > 1023) return 10'd1023;
    return 10'(v);
  endfunction

  task automatic model_reset();
    m_state = 0; m_s1 = 0; m_s2 = 0; m_win = 0; m_left = 0;
    m_armed = 0; m_h1 = 0; m_h2 = 0; m_rr = 0;
  endtask

  // One frame of the match rules, applied with the inputs present at the tick.
  task automatic model_step();
    int nh1, nh2;
    nh1 = (m_state == 1 && bul1_active) ? m_near(bul1x, tank2x) * m_near(bul1y, tank2y) : 0;
    nh2 = (m_state == 1 && bul2_active) ? m_near(bul2x, tank1x) * m_near(bul2y, tank1y) : 0;
    m_rr = 0;
    case (m_state)
      0: if (keycode == 8'h2C) begin
        m_s1 = 0; m_s2 = 0; m_win = 0; m_rr = 1; m_state = 1;
      end
      1: if (m_h1 == 1 || m_h2 == 1) begin
        m_left = 90; m_state = 2;
        if (m_h1 == 1 && m_h2 == 1) m_win = 3;
        else if (m_h1 == 1) begin m_win = 1; if (m_s1 < 15) m_s1++; end
        else begin m_win = 2; if (m_s2 < 15) m_s2++; end
      end
      2: begin
        m_left--;
        if (m_left == 0) m_state = 3;
      end
      3: if (m_s1 >= 5 || m_s2 >= 5) begin
        m_state = 4; m_armed = 0;
      end else begin
        m_rr = 1; m_win = 0; m_state = 1;
      end
      4: if (m_armed == 0) begin
        if (keycode == 8'h00) m_armed = 1;
      end else if (keycode == 8'h2C) begin
        m_state = 0;
      end
      default: m_state = 0;
    endcase
    m_h1 = nh1; m_h2 = nh2;
  endtask

  // Issue one frame_tick, advance the model, and sample round_reset on the two following Clks.
  task automatic do_tick();
    frame_tick = 1'b1;
    @(posedge Clk); #1;
    frame_tick = 1'b0;
    model_step();
    rr_seen = round_reset;
    @(posedge Clk); #1;
    rr_after = round_reset;
  endtask

  task automatic apply_reset();
    Reset = 1'b1;
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b0;
    repeat (2) @(posedge Clk);
    #1 model_reset();
  endtask

  task automatic clear_bullets();
    bul1_active = 1'b0; bul2_active = 1'b0;
  endtask

  // Drain FREEZE and ROUND_OVER with no checking; bounded.
  task automatic run_out_round();
    for (int i = 0; i < 200 && (m_state == 2 || m_state == 3); i++) do_tick();
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    repeat (3) @(posedge Clk);
    #1 Reset = 1'b0;
    @(posedge Clk); #1;
    model_reset();
    checks++; if (round_reset !== 1'b1) begin errors++;
      $display("FAIL reset_rr_pulse got %b want 1", round_reset); end
    checks++; if (state !== 3'd0 || score1 !== 4'd0 || score2 !== 4'd0 || winner !== 2'b00) begin
      errors++; $display("FAIL reset_state got st=%0d s=%0d/%0d w=%b want 0 0/0 00",
                         state, score1, score2, winner); end
    checks++; if (game_active !== 1'b0 || freeze !== 1'b0) begin errors++;
      $display("FAIL reset_flags got ga=%b fz=%b want 0 0", game_active, freeze); end
    @(posedge Clk); #1;
    checks++; if (round_reset !== 1'b0) begin errors++;
      $display("FAIL reset_rr_width got %b want 0", round_reset); end
  endtask

  task automatic test_start();
    keycode = 8'h2C;
    do_tick();
    keycode = 8'h00;
    checks++; if (rr_seen !== 1'b1 || rr_after !== 1'b0) begin errors++;
      $display("FAIL start_rr got %b%b want 10", rr_seen, rr_after); end
    checks++; if (state !== 3'd1 || game_active !== 1'b1 || score1 !== 4'd0 || score2 !== 4'd0)
    begin errors++; $display("FAIL start_play got st=%0d ga=%b s=%0d/%0d want 1 1 0/0",
                             state, game_active, score1, score2); end
  endtask

  task automatic test_hit_freeze();
    int n;
    bul1x = 10'd100; bul1y = 10'd100; tank2x = 10'd110; tank2y = 10'd95; bul1_active = 1'b1;
    do_tick();
    checks++; if (state !== 3'd1) begin errors++;
      $display("FAIL hit_latency got st=%0d want 1", state); end
    clear_bullets();
    do_tick();
    checks++; if (score1 !== 4'd1 || winner !== 2'b01 || state !== 3'd2 || freeze !== 1'b1) begin
      errors++; $display("FAIL hit_score got s1=%0d w=%b st=%0d fz=%b want 1 01 2 1",
                         score1, winner, state, freeze); end
    n = 0;
    while (state == 3'd2 && n < 200) begin do_tick(); n++; end
    checks++; if (n != 90 || state !== 3'd3 || freeze !== 1'b1) begin errors++;
      $display("FAIL freeze_len got n=%0d st=%0d fz=%b want 90 3 1", n, state, freeze); end
    do_tick();
    checks++; if (state !== 3'd1 || rr_seen !== 1'b1 || rr_after !== 1'b0 || winner !== 2'b00)
    begin errors++; $display("FAIL round_over got st=%0d rr=%b%b w=%b want 1 10 00",
                             state, rr_seen, rr_after, winner); end
  endtask

  task automatic test_draw();
    tank1x = 10'd300; tank1y = 10'd300; tank2x = 10'd600; tank2y = 10'd200;
    bul1x = 10'd605; bul1y = 10'd195; bul2x = 10'd295; bul2y = 10'd310;
    bul1_active = 1'b1; bul2_active = 1'b1;
    do_tick();
    clear_bullets();
    do_tick();
    checks++; if (winner !== 2'b11 || state !== 3'd2 || score1 !== 4'd1 || score2 !== 4'd0) begin
      errors++; $display("FAIL draw got w=%b st=%0d s=%0d/%0d want 11 2 1/0",
                         winner, state, score1, score2); end
    run_out_round();
  endtask

  task automatic test_edges();
    int tbl [4][5] = '{'{5, 50, 16, 50, 1}, '{28, 50, 16, 50, 0},
                       '{0, 0, 1000, 0, 0}, '{50, 50, 50, 62, 0}};
    for (int i = 0; i < 4; i++) begin
      bul1x = 10'(tbl[i][0]); bul1y = 10'(tbl[i][1]);
      tank2x = 10'(tbl[i][2]); tank2y = 10'(tbl[i][3]); bul1_active = 1'b1;
      do_tick();
      clear_bullets();
      do_tick();
      checks++;
      if (state !== ((tbl[i][4] == 1) ? 3'd2 : 3'd1) || score1 !== 4'(m_s1)) begin errors++;
        $display("FAIL edge_%0d got st=%0d s1=%0d want hit=%0d s1=%0d",
                 i, state, score1, tbl[i][4], m_s1); end
      run_out_round();
    end
  endtask

  task automatic test_match_over();
    apply_reset();
    keycode = 8'h2C; do_tick(); keycode = 8'h00;
    tank2x = 10'd400; tank2y = 10'd400; bul1x = 10'd405; bul1y = 10'd392;
    for (int k = 1; k <= 5; k++) begin
      bul1_active = 1'b1; do_tick(); clear_bullets(); do_tick();
      for (int i = 0; i < 200 && m_state == 2; i++) do_tick();
      do_tick();
      if (k < 5) begin
        checks++; if (state !== 3'd1 || rr_seen !== 1'b1 || score1 !== 4'(k)) begin errors++;
          $display("FAIL round_%0d got st=%0d rr=%b s1=%0d want 1 1 %0d",
                   k, state, rr_seen, score1, k); end
      end
    end
    checks++; if (state !== 3'd4 || winner !== 2'b01 || rr_seen !== 1'b0 || score1 !== 4'd5)
    begin errors++; $display("FAIL match_over got st=%0d w=%b rr=%b s1=%0d want 4 01 0 5",
                             state, winner, rr_seen, score1); end
    checks++; if (game_active !== 1'b0 || freeze !== 1'b0) begin errors++;
      $display("FAIL match_over_flags got ga=%b fz=%b want 0 0", game_active, freeze); end
    keycode = 8'h2C;
    repeat (3) do_tick();
    checks++; if (state !== 3'd4) begin errors++;
      $display("FAIL held_key got st=%0d want 4", state); end
    keycode = 8'h00; do_tick();
    keycode = 8'h2C; do_tick();
    checks++; if (state !== 3'd0) begin errors++;
      $display("FAIL rearm_key got st=%0d want 0", state); end
    keycode = 8'h00;
  endtask

  task automatic test_reset_mid_freeze();
    keycode = 8'h2C; do_tick(); keycode = 8'h00;
    bul1_active = 1'b1; do_tick(); clear_bullets(); do_tick();
    repeat (40) do_tick();
    checks++; if (state !== 3'd2 || dut.cnt_q !== 7'd40) begin errors++;
      $display("FAIL mid_freeze got st=%0d cnt=%0d want 2 40", state, dut.cnt_q); end
    Reset = 1'b1;
    @(posedge Clk); #1;
    checks++; if (state !== 3'd0 || score1 !== 4'd0 || dut.cnt_q !== 7'd0 || freeze !== 1'b0)
    begin errors++; $display("FAIL reset_abort got st=%0d s1=%0d cnt=%0d fz=%b want 0 0 0 0",
                             state, score1, dut.cnt_q, freeze); end
    Reset = 1'b0;
    @(posedge Clk); #1;
    model_reset();
    checks++; if (round_reset !== 1'b1) begin errors++;
      $display("FAIL reset_abort_rr got %b want 1", round_reset); end
    @(posedge Clk); #1;
  endtask

  task automatic test_illegal_state();
    @(negedge Clk);
    force dut.state_q = 3'd6;
    #1 release dut.state_q;
    @(posedge Clk); #1;
    checks++; if (state !== 3'd0 || game_active !== 1'b0 || freeze !== 1'b0) begin errors++;
      $display("FAIL illegal_state got st=%0d ga=%b fz=%b want 0 0 0",
               state, game_active, freeze); end
    m_state = 0;
  endtask

  task automatic test_random();
    int r;
    apply_reset();
    for (int i = 0; i < 2000; i++) begin
      tank1x = 10'($urandom_range(0, 1023)); tank1y = 10'($urandom_range(0, 1023));
      tank2x = 10'($urandom_range(0, 1023)); tank2y = 10'($urandom_range(0, 1023));
      bul1x = clip(int'(tank2x) + int'($urandom_range(0, 30)) - 15);
      bul1y = clip(int'(tank2y) + int'($urandom_range(0, 30)) - 15);
      bul2x = clip(int'(tank1x) + int'($urandom_range(0, 30)) - 15);
      bul2y = clip(int'(tank1y) + int'($urandom_range(0, 30)) - 15);
      bul1_active = 1'($urandom_range(0, 1));
      bul2_active = 1'($urandom_range(0, 1));
      r = int'($urandom_range(0, 7));
      keycode = (r == 0) ? 8'h2C : ((r == 1) ? 8'h1A : 8'h00);
      do_tick();
      checks++;
      if (state !== 3'(m_state) || score1 !== 4'(m_s1) || score2 !== 4'(m_s2) ||
          winner !== 2'(m_win)) begin errors++;
        $display("FAIL rand_%0d got st=%0d s=%0d/%0d w=%0d want st=%0d s=%0d/%0d w=%0d",
                 i, state, score1, score2, winner, m_state, m_s1, m_s2, m_win); end
      checks++;
      if (rr_seen !== 1'(m_rr) || rr_after !== 1'b0 || game_active !== (m_state == 1) ||
          freeze !== (m_state == 2 || m_state == 3)) begin errors++;
        $display("FAIL rand_out_%0d got rr=%b%b ga=%b fz=%b want rr=%0d0 st=%0d",
                 i, rr_seen, rr_after, game_active, freeze, m_rr, m_state); end
    end
    keycode = 8'h00; clear_bullets();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_start();
    test_hit_freeze();
    test_draw();
    test_edges();
    test_match_over();
    test_reset_mid_freeze();
    test_illegal_state();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
